branch_predict_gshare: RTL and testbench

//  Parametrised global-history branch predictor: 2-bit saturating PHT indexed by PC and a speculative GHR.

---
 rtl/branch_predict_gshare.sv | 149 ++++++++++++++
 tb/tb_branch_predict_gshare.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_gshare.sv
// Global-history branch predictor: 2-bit saturating PHT indexed by PC and speculative GHR,
// concat or gshare-XOR index, GHR repair from the M-stage snapshot, PHT initialised by a sweep FSM.
module branch_predict_gshare #(
  parameter int         GHR_W    = 8,
  parameter int         IDX_W    = 12,
  parameter int         PC_LSB   = 2,
  parameter int         MODE     = 1,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             branchD,
  output logic             pred_takeD,
  output logic [IDX_W-1:0] idxD,
  output logic [GHR_W-1:0] ghrD,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic             ready
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_init_cnt;
  logic             r_ready;
  logic [GHR_W-1:0] r_ghr;
  logic             r_pred_d;
  logic [IDX_W-1:0] r_idx_d;
  logic [GHR_W-1:0] r_ghr_d;
  logic [1:0]       r_pht [DEPTH];

  logic [IDX_W-1:0] w_idx_f;
  logic             w_pred_f;
  logic [GHR_W-1:0] w_ghr_shift;
  logic [GHR_W-1:0] w_ghr_repair;
  logic [1:0]       w_ctr_old;
  logic [1:0]       w_ctr_new;
  logic             w_unused;

  // F-stage index: PC bits above the index window never reach the table.
  generate
    if (MODE == 0) begin : g_concat
      assign w_idx_f = {pcF[PC_LSB +: (IDX_W - GHR_W)], r_ghr};
    end else begin : g_xor
      assign w_idx_f = pcF[PC_LSB +: IDX_W] ^ IDX_W'(r_ghr);
    end
  endgenerate

  assign w_unused = ^{pcF, upd_ghr};
  assign w_pred_f = r_pht[w_idx_f][1];

  // Truncating casts drop the oldest history bit and also cover GHR_W == 1.
  assign w_ghr_shift  = GHR_W'({r_ghr, pred_takeD});
  assign w_ghr_repair = GHR_W'({upd_ghr, upd_taken});

  assign w_ctr_old = r_pht[upd_idx];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_ctr_new = w_ctr_old;
    if (upd_taken) begin
      if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'd1;
    end else begin
      if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + IDX_W'(1);
          if (r_init_cnt == {IDX_W{1'b1}}) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the PHT has no reset; a reset loop over a RAM would not map to memory, the sweep initialises it.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_pht[r_init_cnt] <= INIT_CTR;
    end else if (upd_valid) begin
      r_pht[upd_idx] <= w_ctr_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_d <= 1'b0;
      r_idx_d  <= '0;
      r_ghr_d  <= '0;
    end else if (flushD) begin
      r_pred_d <= 1'b0;
      r_idx_d  <= '0;
      r_ghr_d  <= '0;
    end else if (!stallD) begin
      r_pred_d <= w_pred_f;
      r_idx_d  <= w_idx_f;
      r_ghr_d  <= r_ghr;
    end
  end

  // A resolved mispredict repairs history and discards any same-cycle speculative shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (r_state == ST_RUN) begin
      if (upd_valid && upd_mispred) begin
        r_ghr <= w_ghr_repair;
      end else if (branchD && !stallD && !flushD) begin
        r_ghr <= w_ghr_shift;
      end
    end
  end

  assign pred_takeD = r_ready & branchD & r_pred_d;
  assign idxD       = r_idx_d;
  assign ghrD       = r_ghr_d;
  assign ready      = r_ready;

endmodule

// File: tb/tb_branch_predict_gshare.sv
// Directed bench for branch_predict_gshare: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against a MODE=1 and a MODE=0 instance.
module tb_branch_predict_gshare;

  typedef enum int {S_READY, S_PRED, S_IDX, S_GHR, S_IDX0} sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    int          due;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcF;
  logic        stallD, flushD, branchD;
  logic        upd_valid, upd_taken, upd_mispred;
  logic [11:0] upd_idx;
  logic [7:0]  upd_ghr;

  logic        pred_takeD, ready;
  logic [11:0] idxD;
  logic [7:0]  ghrD;
  logic        pred_takeD0, ready0;
  logic [11:0] idxD0;
  logic [7:0]  ghrD0;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  branch_predict_gshare #(.GHR_W(8), .IDX_W(12), .PC_LSB(2), .MODE(1), .INIT_CTR(2'b10)) dut (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .stallD(stallD), .flushD(flushD), .branchD(branchD),
    .pred_takeD(pred_takeD), .idxD(idxD), .ghrD(ghrD),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .ready(ready)
  );

  branch_predict_gshare #(.GHR_W(8), .IDX_W(12), .PC_LSB(2), .MODE(0), .INIT_CTR(2'b10)) dut0 (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .stallD(stallD), .flushD(flushD), .branchD(branchD),
    .pred_takeD(pred_takeD0), .idxD(idxD0), .ghrD(ghrD0),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .ready(ready0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_READY: return {31'd0, ready};
      S_PRED:  return {31'd0, pred_takeD};
      S_IDX:   return {20'd0, idxD};
      S_GHR:   return {24'd0, ghrD};
      S_IDX0:  return {20'd0, idxD0};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: pops every expectation that is due this cycle and compares mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      n_checks++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, a, e.exp, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_now(input sig_e s, input logic [31:0] v, input string n);
    exp_t e;
    e.sig  = s;
    e.exp  = v;
    e.due  = cyc;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic clr_in();
    branchD     = 1'b0;
    stallD      = 1'b0;
    flushD      = 1'b0;
    upd_valid   = 1'b0;
    upd_mispred = 1'b0;
    upd_taken   = 1'b0;
    upd_idx     = '0;
    upd_ghr     = '0;
  endtask

  task automatic update(input logic [11:0] idx, input logic taken);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = taken;
    step();
    upd_valid = 1'b0;
  endtask

  // Load D from pc, then show the stored bit with branchD under stall so the GHR does not move.
  task automatic observe(input logic [31:0] pc, input logic exp_pred,
                         input logic [11:0] exp_idx, input string n);
    pcF     = pc;
    branchD = 1'b0;
    stallD  = 1'b0;
    step();
    branchD = 1'b1;
    stallD  = 1'b1;
    exp_now(S_PRED, {31'd0, exp_pred}, n);
    exp_now(S_IDX, {20'd0, exp_idx}, {n, "_idx"});
    step();
    branchD = 1'b0;
    stallD  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pcF   = '0;
    clr_in();
    repeat (3) step();
    exp_now(S_READY, 0, "rst_ready");
    exp_now(S_GHR, 0, "rst_ghrd");
    exp_now(S_IDX, 0, "rst_idxd");

    // T1: sweep takes exactly 4096 cycles after release
    rst_n = 1'b1;
    step();
    branchD = 1'b1;
    exp_now(S_READY, 0, "init_ready_first");
    exp_now(S_PRED, 0, "init_pred_gated");
    repeat (4094) step();
    branchD = 1'b0;
    exp_now(S_READY, 0, "init_ready_last");
    step();
    exp_now(S_READY, 1, "init_ready_up");

    // T2: saturating counters, GHR = 0 so idx = pc[13:2]
    observe(32'h14, 1'b1, 12'h005, "t1_init_ctr");
    repeat (3) update(12'h005, 1'b0);
    observe(32'h14, 1'b0, 12'h005, "t2_sat_low");
    update(12'h005, 1'b1);
    observe(32'h14, 1'b0, 12'h005, "t2_inc_01");
    pcF       = 32'h14;
    upd_valid = 1'b1;
    upd_idx   = 12'h005;
    upd_taken = 1'b1;
    step();
    upd_valid = 1'b0;
    branchD   = 1'b1;
    stallD    = 1'b1;
    exp_now(S_PRED, 0, "no_bypass_old");
    step();
    branchD = 1'b0;
    stallD  = 1'b0;
    observe(32'h14, 1'b1, 12'h005, "t2_inc_10");
    repeat (3) update(12'h00A, 1'b1);
    update(12'h00A, 1'b0);
    observe(32'h28, 1'b1, 12'h00A, "t2_sat_high");

    // T5/T3: index forms and speculative shift
    pcF = 32'h0000_1234;
    step();
    branchD = 1'b1;
    exp_now(S_PRED, 1, "pred_48d");
    exp_now(S_IDX, 12'h48D, "t5_idx_mode1_g00");
    exp_now(S_IDX0, 12'hD00, "t5_idx_mode0_g00");
    exp_now(S_GHR, 0, "ghrd_g00");
    step();
    branchD = 1'b0;
    exp_now(S_GHR, 0, "t3_shadow_ghrd");
    step();
    exp_now(S_GHR, 8'h01, "t3_ghr_shift");
    exp_now(S_IDX, 12'h48C, "idx_mode1_g01");
    exp_now(S_IDX0, 12'hD01, "idx_mode0_g01");
    pcF     = '0;
    branchD = 1'b1;
    stallD  = 1'b1;
    step();
    exp_now(S_IDX, 12'h48C, "stall_hold_idx");
    branchD = 1'b0;
    stallD  = 1'b0;
    step();
    exp_now(S_GHR, 8'h01, "t3_stall_no_shift");
    exp_now(S_IDX, 12'h001, "idx_after_stall");
    flushD = 1'b1;
    step();
    flushD  = 1'b0;
    branchD = 1'b1;
    exp_now(S_IDX, 0, "flush_clear_idx");
    exp_now(S_GHR, 0, "flush_clear_ghr");
    exp_now(S_PRED, 0, "flush_clear_pred");
    step();
    branchD = 1'b0;
    step();
    exp_now(S_GHR, 8'h02, "shift_not_taken");
    exp_now(S_IDX, 12'h002, "idx_g02");

    // T4: repair wins over a same-cycle D shift
    upd_valid   = 1'b1;
    upd_mispred = 1'b1;
    upd_ghr     = 8'h5A;
    upd_taken   = 1'b0;
    upd_idx     = 12'h0FF;
    branchD     = 1'b1;
    step();
    clr_in();
    step();
    exp_now(S_GHR, 8'hB4, "t4_repair_wins");

    // T5: GHR = 0xFF via repair, then both index forms
    upd_valid   = 1'b1;
    upd_mispred = 1'b1;
    upd_ghr     = 8'h7F;
    upd_taken   = 1'b1;
    upd_idx     = 12'h0FF;
    step();
    clr_in();
    pcF = 32'h0000_1234;
    step();
    exp_now(S_IDX, 12'h472, "t5_idx_mode1_gff");
    exp_now(S_IDX0, 12'hDFF, "t5_idx_mode0_gff");
    exp_now(S_GHR, 8'hFF, "t5_ghrd_ff");
    branchD = 1'b1;
    stallD  = 1'b1;
    exp_now(S_PRED, 1, "t5_pred_472");
    step();
    clr_in();
    repeat (2) update(12'h005, 1'b0);

    // T6: async reset from RUN, then reset again mid-sweep
    rst_n = 1'b0;
    exp_now(S_GHR, 0, "rst_async_ghrd");
    exp_now(S_IDX, 0, "rst_async_idxd");
    exp_now(S_READY, 0, "rst_async_ready");
    step();
    rst_n       = 1'b1;
    pcF         = 32'h0000_1234;
    upd_valid   = 1'b1;
    upd_mispred = 1'b1;
    upd_idx     = 12'h005;
    upd_taken   = 1'b0;
    upd_ghr     = 8'h7F;
    repeat (99) step();
    exp_now(S_IDX, 12'h48D, "init_d_load");
    exp_now(S_GHR, 0, "init_ghr_held");
    step();
    rst_n = 1'b0;
    exp_now(S_IDX, 0, "mid_sweep_rst_idx");
    exp_now(S_READY, 0, "mid_sweep_rst_ready");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4095) step();
    exp_now(S_READY, 0, "resweep_ready_low");
    step();
    clr_in();
    exp_now(S_READY, 1, "resweep_ready_up");
    exp_now(S_GHR, 0, "resweep_ghr_zero");
    observe(32'h14, 1'b1, 12'h005, "resweep_pht");

    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      n_fail += q.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
